udp_framer: RTL and testbench
=============================

UDP_FRAMER -- requirements
Module: udp_framer

Interface
REQ-001 Parameter PAYLOAD_LEN, default 1024: UDP payload bytes per frame; legal range 18..1472.
REQ-002 Parameter DST_MAC, default 48'hFFFFFFFFFFFF: destination MAC address.
REQ-003 Parameter SRC_MAC, default 48'h02_00_00_00_00_01: source MAC address.
REQ-004 Parameter SRC_IP, default 32'hC0A80102: source IPv4 address.
REQ-005 Parameter DST_IP, default 32'hC0A80101: destination IPv4 address.
REQ-006 Parameters SRC_PORT and DST_PORT, default 16'd5000 each: UDP ports.
REQ-007 tx_clk  in  1  sole clock; all logic SHALL be posedge tx_clk.
REQ-008 rstn  in  1  reset, synchronous and active-low.
REQ-009 s_data  in  8  payload byte from the sample packer.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  payload byte accepted when s_valid & s_ready.
REQ-012 tx_data  out  8  byte to the MAC transmit interface.
REQ-013 tx_sop  out  1  first byte of frame.
REQ-014 tx_eop  out  1  last byte of frame.
REQ-015 tx_err  out  1  tied 0.
REQ-016 tx_wren  out  1  byte write strobe to the MAC.
REQ-017 tx_rdy  in  1  MAC can accept a byte this cycle.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 frames_sent  out  16  count of completed frames; wraps.

Function
REQ-020 The block SHALL emit one Ethernet/IPv4/UDP frame per PAYLOAD_LEN payload bytes: 42 header bytes, then the payload, in network byte order, without FCS or preamble.
REQ-021 Header bytes 0-13: DST_MAC, SRC_MAC, ethertype 0x0800.
REQ-022 Header bytes 14-33: 0x45, 0x00, total_len = PAYLOAD_LEN+28, ident, 0x4000 (DF), TTL 0x40, protocol 0x11, checksum, SRC_IP, DST_IP.
REQ-023 Header bytes 34-41: SRC_PORT, DST_PORT, udp_len = PAYLOAD_LEN+8, UDP checksum 0x0000.
REQ-024 IPv4 checksum: 16-bit one's-complement sum of the nine non-checksum header words; fold carries until 16 bits; bitwise invert; at least 20-bit accumulator.
REQ-025 States: IDLE, CSUM, HDR, PAYLOAD.
REQ-026 IDLE->CSUM when s_valid=1; CSUM lasts exactly 1 cycle, then HDR.
REQ-027 HDR->PAYLOAD after header byte 41 is written; PAYLOAD->IDLE after payload byte PAYLOAD_LEN-1 is written.
REQ-028 A byte is transferred only in a cycle with tx_wren=1; tx_wren SHALL never be 1 while tx_rdy=0.
REQ-029 HDR: tx_wren = tx_rdy; byte index advances only on transfer.
REQ-030 PAYLOAD: s_ready = tx_rdy, tx_wren = s_valid & tx_rdy, tx_data = s_data (combinational pass-through, zero latency).
REQ-031 s_ready SHALL be 0 outside PAYLOAD.
REQ-032 tx_sop=1 only with header byte 0; tx_eop=1 only with the last payload byte.
REQ-033 A stall on s_valid or tx_rdy mid-frame holds state and index; no bytes are dropped or duplicated.
REQ-034 Byte index counter is 11 bits and resets to 0 on each state entry.
REQ-035 ident starts at 0 and increments by 1 on each eop transfer; 0xFFFF wraps to 0x0000.
REQ-036 frames_sent increments on the same event.
REQ-037 A new frame SHALL NOT start in the eop cycle; IDLE lasts at least one cycle between frames.

Reset
REQ-038 rstn=0 at a clock edge SHALL force the following, at any point including mid-frame: state IDLE, index 0, ident 0, frames_sent 0.
REQ-039 While state is IDLE: tx_wren=0, tx_sop=0, tx_eop=0, s_ready=0, busy=0, tx_data=0x00.
REQ-040 A frame truncated by reset is not resumed; the MAC SHALL be reset together with this block.

Verification
REQ-041 Setup: PAYLOAD_LEN=18, default parameters, tx_rdy=1, 18 payload bytes 0x00..0x11 streamed continuously. Required: 60 consecutive tx_wren cycles starting 2 cycles after the first s_valid; byte 16-17 = 0x002E; bytes 24-25 = 0xB76B; bytes 38-39 = 0x001A; sop at byte 0; eop with payload byte 0x11.
REQ-042 Setup: second identical frame. Required: ident = 0x0001 and checksum = 0xB76A; frames_sent = 2.
REQ-043 Setup: tx_rdy toggled pseudo-randomly. Required: tx_wren never 1 while tx_rdy=0; byte sequence identical to REQ-041.
REQ-044 Setup: s_valid held low 5 cycles after payload byte 3. Required: tx_wren low 5 cycles, then bytes continue with no gap or duplicate.
REQ-045 Setup: rstn low for 1 cycle at header byte 20. Required: next cycle busy=0 and tx_wren=0; next frame restarts at sop with ident 0x0000.
REQ-046 Setup: ident preloaded to 0xFFFF by sending 65535 frames (or by force). Required: the following frame carries ident 0x0000.

Source files
------------

// File: rtl/udp_framer.sv
`default_nettype none
// ============================================================================
// Module   : udp_framer
// Purpose  : Wraps a continuous payload byte stream into Ethernet/IPv4/UDP
//            frames: 42 header bytes followed by PAYLOAD_LEN payload bytes,
//            network byte order, no preamble and no FCS. The IPv4 header
//            checksum is computed in a one-cycle CSUM state before each frame.
// Ports    : tx_clk      - sole clock (rising edge)
//            rstn        - synchronous active-low reset
//            s_data/s_valid/s_ready - payload byte stream in
//            tx_data/tx_sop/tx_eop/tx_err/tx_wren/tx_rdy - MAC transmit side
//            busy        - high whenever a frame is in progress
//            frames_sent - completed frame count, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module udp_framer #(
  parameter int          PAYLOAD_LEN = 1024,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0102,
  parameter logic [31:0] DST_IP      = 32'hC0A8_0101,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd5000
) (
  input  logic        tx_clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        tx_err,
  output logic        tx_wren,
  input  logic        tx_rdy,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [15:0] C_TOTAL_LEN = 16'(PAYLOAD_LEN + 28);
  localparam logic [15:0] C_UDP_LEN   = 16'(PAYLOAD_LEN + 8);
  localparam logic [10:0] C_PAY_LAST  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0] C_HDR_LAST  = 11'd41;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CSUM    = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [15:0] ident_q, ident_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] csum_q, csum_d;

  // One's-complement sum of the nine non-checksum IPv4 header words. The
  // 20-bit accumulator cannot overflow for nine 16-bit terms; two folds are
  // enough because the first fold leaves at most a single carry bit.
  logic [19:0] csum_acc;
  logic [16:0] csum_fold1;
  logic [15:0] csum_fold2;

  always_comb begin
    csum_acc = 20'(16'h4500) + 20'(C_TOTAL_LEN) + 20'(ident_q)
             + 20'(16'h4000) + 20'(16'h4011)
             + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
             + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    csum_fold1 = 17'(csum_acc[15:0]) + 17'(csum_acc[19:16]);
    csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);
  end

  // Whole header as one vector, byte 0 in the MSBs; the current byte is
  // selected by shifting it to the top.
  logic [335:0] hdr_vec;
  logic [335:0] hdr_shift;

  assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800,
                    8'h45, 8'h00, C_TOTAL_LEN, ident_q, 16'h4000,
                    8'h40, 8'h11, csum_q, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, C_UDP_LEN, 16'h0000};
  assign hdr_shift = hdr_vec << {idx_q[5:0], 3'b000};

  assign tx_err      = 1'b0;
  assign frames_sent = frames_q;

  always_ff @(posedge tx_clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      idx_q    <= 11'd0;
      ident_q  <= 16'd0;
      frames_q <= 16'd0;
      csum_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ident_q  <= ident_d;
      frames_q <= frames_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ident_d  = ident_q;
    frames_d = frames_q;
    csum_d   = csum_q;
    s_ready  = 1'b0;
    tx_data  = 8'h00;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_wren  = 1'b0;
    busy     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = CSUM;
          idx_d   = 11'd0;
        end
      end

      CSUM: begin
        busy    = 1'b1;
        csum_d  = ~csum_fold2;
        state_d = HDR;
        idx_d   = 11'd0;
      end

      HDR: begin
        busy    = 1'b1;
        tx_wren = tx_rdy;
        tx_data = hdr_shift[335:328];
        tx_sop  = tx_rdy && (idx_q == 11'd0);
        if (tx_rdy) begin
          if (idx_q == C_HDR_LAST) begin
            state_d = PAYLOAD;
            idx_d   = 11'd0;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      PAYLOAD: begin
        busy    = 1'b1;
        s_ready = tx_rdy;
        tx_wren = s_valid && tx_rdy;
        tx_data = s_data;
        tx_eop  = s_valid && tx_rdy && (idx_q == C_PAY_LAST);
        if (s_valid && tx_rdy) begin
          if (idx_q == C_PAY_LAST) begin
            state_d  = IDLE;
            idx_d    = 11'd0;
            ident_d  = ident_q + 16'd1;
            frames_d = frames_q + 16'd1;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 11'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_framer
// Purpose  : Scoreboard bench for udp_framer. A frame-level reference model
//            pushes the expected byte stream into a queue; a monitor pops and
//            compares every transferred byte with its sop/eop flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_framer;

  localparam int          PLEN    = 18;
  localparam logic [47:0] T_DMAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] T_SMAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] T_SIP   = 32'hC0A8_0102;
  localparam logic [31:0] T_DIP   = 32'hC0A8_0101;
  localparam logic [15:0] T_SPORT = 16'd5000;
  localparam logic [15:0] T_DPORT = 16'd5000;

  logic        tx_clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_sop, tx_eop, tx_err, tx_wren;
  logic        tx_rdy;
  logic        busy;
  logic [15:0] frames_sent;

  udp_framer #(.PAYLOAD_LEN(PLEN)) dut (
    .tx_clk(tx_clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_err(tx_err), .tx_wren(tx_wren), .tx_rdy(tx_rdy), .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t        exp_q[$];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;
  logic [7:0]  cap  [0:63];
  int          xcyc [0:63];
  int          bcnt = 0;
  logic [15:0] model_ident  = 16'd0;
  logic [15:0] model_frames = 16'd0;
  int          valid_cyc = 0;

  always @(posedge tx_clk) cyc++;

  // MAC ready: steady or pseudo-random, changed just after each edge.
  always @(posedge tx_clk) begin
    #1;
    tx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the frame as a byte list derived from the header layout.
  task automatic push_frame(input logic [15:0] id, input logic [7:0] pl [PLEN]);
    logic [7:0]  hb [42];
    logic [15:0] words [9];
    int          sum;
    logic [15:0] ck;
    logic [15:0] tl;
    logic [15:0] ul;
    tl = 16'(PLEN + 28);
    ul = 16'(PLEN + 8);
    words = '{16'h4500, tl, id, 16'h4000, 16'h4011,
              T_SIP[31:16], T_SIP[15:0], T_DIP[31:16], T_DIP[15:0]};
    sum = 0;
    foreach (words[k]) sum += int'(words[k]);
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    ck = ~sum[15:0];
    for (int k = 0; k < 6; k++) begin
      hb[k]     = T_DMAC[47 - 8*k -: 8];
      hb[6 + k] = T_SMAC[47 - 8*k -: 8];
    end
    hb[12] = 8'h08; hb[13] = 8'h00;
    hb[14] = 8'h45; hb[15] = 8'h00;
    hb[16] = tl[15:8]; hb[17] = tl[7:0];
    hb[18] = id[15:8]; hb[19] = id[7:0];
    hb[20] = 8'h40; hb[21] = 8'h00;
    hb[22] = 8'h40; hb[23] = 8'h11;
    hb[24] = ck[15:8]; hb[25] = ck[7:0];
    for (int k = 0; k < 4; k++) begin
      hb[26 + k] = T_SIP[31 - 8*k -: 8];
      hb[30 + k] = T_DIP[31 - 8*k -: 8];
    end
    hb[34] = T_SPORT[15:8]; hb[35] = T_SPORT[7:0];
    hb[36] = T_DPORT[15:8]; hb[37] = T_DPORT[7:0];
    hb[38] = ul[15:8]; hb[39] = ul[7:0];
    hb[40] = 8'h00; hb[41] = 8'h00;
    for (int k = 0; k < 42; k++) exp_q.push_back('{hb[k], k == 0, 1'b0});
    for (int k = 0; k < PLEN; k++) exp_q.push_back('{pl[k], 1'b0, k == PLEN - 1});
  endtask

  // Monitor: compares each transferred byte against the scoreboard.
  always @(negedge tx_clk) begin
    if (mon_en) begin
      check("wren_while_not_rdy", {31'd0, tx_wren & ~tx_rdy}, 32'd0);
      if (tx_wren) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.sop) bcnt = 0;
          check("byte", {24'd0, tx_data}, {24'd0, e.d});
          check("sop", {31'd0, tx_sop}, {31'd0, e.sop});
          check("eop", {31'd0, tx_eop}, {31'd0, e.eop});
          if (bcnt < 64) begin
            cap[bcnt]  = tx_data;
            xcyc[bcnt] = cyc;
          end
          bcnt++;
        end
      end
    end
  end

  // Issues one frame: model first, then drives payload with optional gap.
  task automatic run_frame(input logic [7:0] pl [PLEN], input int gap_after);
    int  i;
    int  guard;
    bit  acc;
    push_frame(model_ident, pl);
    model_ident++;
    model_frames++;
    i = 0;
    guard = 0;
    s_data  = pl[0];
    s_valid = 1'b1;
    valid_cyc = cyc;
    while (i < PLEN) begin
      @(negedge tx_clk);
      acc = s_valid && s_ready;
      @(posedge tx_clk);
      #1;
      guard++;
      if (guard > 2000) begin
        check("drive_timeout", 32'd1, 32'd0);
        break;
      end
      if (acc) begin
        if (i == gap_after) begin
          s_valid = 1'b0;
          repeat (5) @(posedge tx_clk);
          #1;
          s_valid = 1'b1;
        end
        i++;
        if (i < PLEN) s_data = pl[i];
      end
    end
    s_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge tx_clk);
      guard++;
    end
    check("frame_drained", exp_q.size(), 32'd0);
    @(posedge tx_clk);
    #1;
  endtask

  logic [7:0] pl_seq [PLEN];
  logic [7:0] pl_rnd [PLEN];
  int         cnt;

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; tx_rdy = 1'b1;
    for (int k = 0; k < PLEN; k++) pl_seq[k] = 8'(k);
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wren", {31'd0, tx_wren}, 32'd0);
    check("rst_sready", {31'd0, s_ready}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_frames", {16'd0, frames_sent}, 32'd0);
    check("rst_err", {31'd0, tx_err}, 32'd0);
    @(posedge tx_clk); #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    // Reference frame: continuous, ready always high.
    run_frame(pl_seq, -1);
    check("f1_latency", 32'(xcyc[0] - valid_cyc), 32'd2);
    check("f1_span", 32'(xcyc[59] - xcyc[0]), 32'd59);
    check("f1_total_len", {16'd0, cap[16], cap[17]}, 32'h002E);
    check("f1_ident", {16'd0, cap[18], cap[19]}, 32'h0000);
    check("f1_csum", {16'd0, cap[24], cap[25]}, 32'hB76B);
    check("f1_udp_len", {16'd0, cap[38], cap[39]}, 32'h001A);
    check("f1_frames", {16'd0, frames_sent}, 32'd1);
    check("f1_idle_busy", {31'd0, busy}, 32'd0);

    run_frame(pl_seq, -1);
    check("f2_ident", {16'd0, cap[18], cap[19]}, 32'h0001);
    check("f2_csum", {16'd0, cap[24], cap[25]}, 32'hB76A);
    check("f2_frames", {16'd0, frames_sent}, 32'd2);

    // Back-pressure from the MAC.
    rdy_rand = 1'b1;
    run_frame(pl_seq, -1);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < PLEN; k++) pl_rnd[k] = 8'($urandom);
      run_frame(pl_rnd, -1);
    end
    rdy_rand = 1'b0;
    @(posedge tx_clk); #1;

    // Source stall after payload byte 3.
    for (int k = 0; k < PLEN; k++) pl_rnd[k] = 8'($urandom);
    run_frame(pl_rnd, 3);
    check("gap_len", 32'(xcyc[46] - xcyc[45]), 32'd6);
    check("frames_model", {16'd0, frames_sent}, {16'd0, model_frames});

    // Reset in the middle of the header.
    mon_en = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h00;
    cnt = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge tx_clk);
      if (tx_wren) begin
        if (cnt == 20) begin
          rstn = 1'b0;
          s_valid = 1'b0;
          break;
        end
        cnt++;
      end
    end
    check("rst_hit_byte20", 32'(cnt), 32'd20);
    @(posedge tx_clk); #1;
    rstn = 1'b1;
    @(negedge tx_clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wren", {31'd0, tx_wren}, 32'd0);
    check("midrst_frames", {16'd0, frames_sent}, 32'd0);
    model_ident  = 16'd0;
    model_frames = 16'd0;
    @(posedge tx_clk); #1;
    mon_en = 1'b1;
    run_frame(pl_seq, -1);
    check("postrst_ident", {16'd0, cap[18], cap[19]}, 32'h0000);
    check("postrst_csum", {16'd0, cap[24], cap[25]}, 32'hB76B);

    // Identification wrap.
    force dut.ident_q = 16'hFFFF;
    @(posedge tx_clk); #1;
    release dut.ident_q;
    model_ident = 16'hFFFF;
    run_frame(pl_seq, -1);
    check("wrap_ident_ffff", {16'd0, cap[18], cap[19]}, 32'hFFFF);
    run_frame(pl_seq, -1);
    check("wrap_ident_0000", {16'd0, cap[18], cap[19]}, 32'h0000);
    check("wrap_frames", {16'd0, frames_sent}, {16'd0, model_frames});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute run-time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
